// File: rtl/keypad_pkg.sv
// Shared types, key layout and row arbitration for the 4x4 hex keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } scan_state_t;

  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // Rows are active-low; the lowest-numbered low row wins.
  function automatic logic [1:0] row_priority(input logic [3:0] rows_n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows_n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer; resets to all-ones so idle (pulled-up) rows read as released.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: one-cold column drive, debounced press/release, one code per press.
// Optional auto-repeat while held: define KEYPAD_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 4800,
  parameter int DEBOUNCE_SCANS = 20,
  parameter int REPEAT_DWELLS  = 2500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_DWELLS < 1) begin : g_bad_params
    $error("keypad_scanner: SCAN_DIV must be >= 4, counts must be >= 1");
  end

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

  logic [DIV_W-1:0] r_div;
  logic             w_tick;
  logic [3:0]       w_row_sync;

  scan_state_t      r_state,   w_state_n;
  logic [3:0]       r_col,     w_col_n;
  logic [1:0]       r_col_idx, w_col_idx_n;
  logic [1:0]       r_row_idx, w_row_idx_n;
  logic [CNT_W-1:0] r_cnt,     w_cnt_n;
  logic [3:0]       r_key,     w_key_n;
  logic             r_valid,   w_valid_n;
  logic             r_held,    w_held_n;
  logic [3:0]       w_col_adv;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_DWELLS + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_DWELLS - 1);
  logic [REP_W-1:0] r_rep, w_rep_n;
`endif

  sync_2ff #(.WIDTH(4)) u_row_sync (
    .clk   (clk),
    .rst_n (reset),
    .i_d   (row),
    .o_q   (w_row_sync)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_div <= '0;
    else        r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
  end

  assign w_tick    = (r_div == DIV_LAST);
  assign w_col_adv = {r_col[2:0], r_col[3]};

  // The column register doubles as the captured column while DEBOUNCE/HELD freeze it.
  always_comb begin
    w_state_n   = r_state;
    w_col_n     = r_col;
    w_col_idx_n = r_col_idx;
    w_row_idx_n = r_row_idx;
    w_cnt_n     = r_cnt;
    w_key_n     = r_key;
    w_valid_n   = 1'b0;
    w_held_n    = r_held;
`ifdef KEYPAD_REPEAT_EN
    w_rep_n     = r_rep;
`endif
    if (w_tick) begin
      case (r_state)
        SCAN: begin
          if (w_row_sync != 4'hF) begin
            w_row_idx_n = row_priority(w_row_sync);
            w_cnt_n     = CNT_W'(1);
            w_state_n   = DEBOUNCE;
          end else begin
            w_col_n     = w_col_adv;
            w_col_idx_n = r_col_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (!w_row_sync[r_row_idx]) begin
            if (r_cnt >= CNT_LAST) begin
              w_key_n   = KEYMAP[r_row_idx][r_col_idx];
              w_valid_n = 1'b1;
              w_held_n  = 1'b1;
              w_cnt_n   = '0;
              w_state_n = HELD;
`ifdef KEYPAD_REPEAT_EN
              w_rep_n   = '0;
`endif
            end else begin
              w_cnt_n = r_cnt + CNT_W'(1);
            end
          end else begin
            w_state_n   = SCAN;
            w_col_n     = w_col_adv;
            w_col_idx_n = r_col_idx + 2'd1;
          end
        end
        HELD: begin
          if (w_row_sync[r_row_idx]) begin
`ifdef KEYPAD_REPEAT_EN
            w_rep_n = '0;
`endif
            if (r_cnt >= CNT_LAST) begin
              w_held_n    = 1'b0;
              w_cnt_n     = '0;
              w_state_n   = SCAN;
              w_col_n     = w_col_adv;
              w_col_idx_n = r_col_idx + 2'd1;
            end else begin
              w_cnt_n = r_cnt + CNT_W'(1);
            end
          end else begin
            w_cnt_n = '0;
`ifdef KEYPAD_REPEAT_EN
            if (r_rep >= REP_LAST) begin
              w_valid_n = 1'b1;
              w_rep_n   = '0;
            end else begin
              w_rep_n = r_rep + REP_W'(1);
            end
`endif
          end
        end
        default: w_state_n = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= SCAN;
      r_col     <= 4'b1110;
      r_col_idx <= 2'd0;
      r_row_idx <= 2'd0;
      r_cnt     <= '0;
      r_key     <= 4'h0;
      r_valid   <= 1'b0;
      r_held    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rep     <= '0;
`endif
    end else begin
      r_state   <= w_state_n;
      r_col     <= w_col_n;
      r_col_idx <= w_col_idx_n;
      r_row_idx <= w_row_idx_n;
      r_cnt     <= w_cnt_n;
      r_key     <= w_key_n;
      r_valid   <= w_valid_n;
      r_held    <= w_held_n;
`ifdef KEYPAD_REPEAT_EN
      r_rep     <= w_rep_n;
`endif
    end
  end

  assign col       = r_col;
  assign key       = r_key;
  assign key_valid = r_valid;
  assign key_held  = r_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad short model, key table, directed corner cases, random presses.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 3;
  localparam int RD = 5;
`ifdef KEYPAD_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;
  logic [15:0] pressed;

  int n_cmp;
  int n_fail;
  int bcyc;
  int pulses;
  logic prev_v;
  logic dbl = 1'b0;

  typedef struct {
    int         r;
    int         c;
    logic [3:0] exp;
  } vec_t;
  vec_t tbl[16];

  string KEYS = "123A456B789CE0FD";

  keypad_scanner #(
    .SCAN_DIV       (SD),
    .DEBOUNCE_SCANS (DB),
    .REPEAT_DWELLS  (RD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Pressed switch shorts its row to its column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) bcyc <= 0;
    else        bcyc <= (bcyc == SD-1) ? 0 : bcyc + 1;
  end

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      pulses <= 0;
      prev_v <= 1'b0;
    end else begin
      prev_v <= key_valid;
      if (key_valid) pulses <= pulses + 1;
      if (key_valid && prev_v) dbl <= 1'b1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      do begin
        @(posedge clk);
        #1;
      end while (bcyc != 0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_pulse(input int max_clk, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_clk && !ok; i++) begin
      @(posedge clk);
      #1;
      if (key_valid) ok = 1'b1;
    end
    chk(nm, int'(ok), 1);
  endtask

  task automatic wait_released(input int max_clk, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_clk && !ok; i++) begin
      @(posedge clk);
      #1;
      if (!key_held) ok = 1'b1;
    end
    chk(nm, int'(ok), 1);
  endtask

  function automatic int hexval(input byte ch);
    if (ch >= "A") return int'(ch) - int'("A") + 10;
    return int'(ch) - int'("0");
  endfunction

  initial begin
    logic [3:0] expc;
    logic [3:0] c0;
    int p0;
    int idx;
    n_cmp   = 0;
    n_fail  = 0;
    reset   = 1'b0;
    pressed = '0;
    tbl[0]  = '{0, 0, 4'h1}; tbl[1]  = '{0, 1, 4'h2}; tbl[2]  = '{0, 2, 4'h3}; tbl[3]  = '{0, 3, 4'hA};
    tbl[4]  = '{1, 0, 4'h4}; tbl[5]  = '{1, 1, 4'h5}; tbl[6]  = '{1, 2, 4'h6}; tbl[7]  = '{1, 3, 4'hB};
    tbl[8]  = '{2, 0, 4'h7}; tbl[9]  = '{2, 1, 4'h8}; tbl[10] = '{2, 2, 4'h9}; tbl[11] = '{2, 3, 4'hC};
    tbl[12] = '{3, 0, 4'hE}; tbl[13] = '{3, 1, 4'h0}; tbl[14] = '{3, 2, 4'hF}; tbl[15] = '{3, 3, 4'hD};

    // Idle scanning
    do_reset();
    chk("rst_col", col, 4'hE);
    chk("rst_key", key, 0);
    chk("rst_valid", key_valid, 0);
    chk("rst_held", key_held, 0);
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      expc = 4'hF ^ (4'b0001 << (k % 4));
      chk("t1_col", col, expc);
    end
    chk("t1_pulses", pulses, 0);
    chk("t1_key", key, 0);
    chk("t1_held", key_held, 0);

    // Stable press r1/c2, then release
    do_reset();
    pressed[1*4+2] = 1'b1;
    tick(3);
    chk("t2_frozen_col", col, 4'hB);
    chk("t2_early_valid", key_valid, 0);
    tick(1);
    chk("t2_mid_valid", key_valid, 0);
    tick(1);
    chk("t2_valid", key_valid, 1);
    chk("t2_key", key, 4'h6);
    chk("t2_held", key_held, 1);
    @(posedge clk);
    #1;
    chk("t2_valid_width", key_valid, 0);
    pressed = '0;
    tick(2);
    chk("t2_held_pre_rel", key_held, 1);
    chk("t2_col_pre_rel", col, 4'hB);
    tick(1);
    chk("t2_held_rel", key_held, 0);
    chk("t2_col_rel", col, 4'h7);
    chk("t2_pulses", pulses, 1);

    // Bouncing contact never qualifies
    pressed = '0;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      pressed[0] = (k % 2 == 0);
      tick(1);
    end
    pressed = '0;
    chk("t3_pulses", pulses, 0);
    chk("t3_held", key_held, 0);
    c0 = col;
    tick(1);
    chk("t3_scan_resumes", col, {c0[2:0], c0[3]});
    pressed[0] = 1'b1;
    wait_pulse(20*SD, "t3_final_timeout");
    chk("t3_key", key, 4'h1);
    pressed = '0;
    wait_released(20*SD, "t3_rel_timeout");

    // Second key ignored while held; lowest row wins
    do_reset();
    pressed[3*4+1] = 1'b1;
    wait_pulse(20*SD, "t4_acc_timeout");
    chk("t4_key0", key, 4'h0);
    pressed[0*4+3] = 1'b1;
    tick(4);
    chk("t4_key_kept", key, 4'h0);
    chk("t4_held", key_held, 1);
    chk("t4_col_frozen", col, 4'hD);
    chk("t4_one_pulse", pulses, 1);
    pressed = '0;
    wait_released(20*SD, "t4_rel_timeout");
    pressed[2*4+0] = 1'b1;
    pressed[3*4+0] = 1'b1;
    wait_pulse(20*SD, "t4_multi_timeout");
    chk("t4_priority_key", key, 4'h7);
    pressed = '0;
    wait_released(20*SD, "t4_rel2_timeout");

    // Async reset during HELD, key still down afterwards
    do_reset();
    pressed[2*4+3] = 1'b1;
    wait_pulse(20*SD, "t5_acc_timeout");
    chk("t5_key", key, 4'hC);
    tick(1);
    reset = 1'b0;
    #1;
    chk("t5_async_col", col, 4'hE);
    chk("t5_async_key", key, 0);
    chk("t5_async_valid", key_valid, 0);
    chk("t5_async_held", key_held, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_pulse(20*SD, "t5_redetect_timeout");
    chk("t5_redetect_key", key, 4'hC);
    tick(1);
    chk("t5_pulses", pulses, 1);
    pressed = '0;
    wait_released(20*SD, "t5_rel_timeout");

    // Long hold: repeat pulses only when the repeat feature is built in
    do_reset();
    pressed[2*4+3] = 1'b1;
    wait_pulse(20*SD, "t6_acc_timeout");
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      chk("t6_valid", key_valid, int'(REP_ON && (k % RD == 0)));
      chk("t6_key", key, 4'hC);
    end
    @(negedge clk);
    chk("t6_pulses", pulses, REP_ON ? 5 : 1);
    pressed = '0;
    wait_released(20*SD, "t6_rel_timeout");

    // Every key position, one at a time
    do_reset();
    for (int i = 0; i < 16; i++) begin
      pressed[tbl[i].r*4 + tbl[i].c] = 1'b1;
      wait_pulse(20*SD, "tbl_timeout");
      chk("tbl_key", key, tbl[i].exp);
      chk("tbl_held", key_held, 1);
      expc = 4'hF ^ (4'b0001 << tbl[i].c);
      chk("tbl_col", col, expc);
      pressed = '0;
      wait_released(20*SD, "tbl_rel_timeout");
    end

    // Random presses with optional glitch; one code per press
    do_reset();
    for (int it = 0; it < 20; it++) begin
      idx = $urandom_range(0, 15);
      p0  = pulses;
      if ($urandom_range(0, 1) == 1) begin
        pressed[idx] = 1'b1;
        tick(1);
        pressed[idx] = 1'b0;
        tick(1);
      end
      pressed[idx] = 1'b1;
      wait_pulse(20*SD, "rnd_timeout");
      chk("rnd_key", key, hexval(KEYS[idx]));
      chk("rnd_held", key_held, 1);
      tick($urandom_range(0, 3));
      pressed[idx] = 1'b0;
      wait_released(20*SD, "rnd_rel_timeout");
      @(negedge clk);
      chk("rnd_pulses", pulses - p0, 1);
      tick($urandom_range(0, 2));
    end

    chk("valid_single_cycle", int'(dbl), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
